// File: rtl/spi_omega_master_pkg.sv
// Shared definitions for the omega SPI link: FSM states, word width default,
// and the SPI mode constant that transmitter and receiver must agree on.
package spi_omega_master_pkg;

  localparam int WORD_W_DEF = 64;

  // {CPOL, CPHA}; mode 0. The omega receiver imports the same value.
  localparam logic [1:0] SPI_MODE = 2'b00;
  localparam logic       SCK_IDLE = SPI_MODE[1];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_omega_master_phase.sv
// Loadable down-counter shared by all timed FSM states; o_tc is high while the
// count is zero, so a load of N-1 yields a state lasting exactly N cycles.
module spi_phase_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               r_cnt <= '0;
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/spi_omega_master.sv
// Mode-0 SPI master: shifts a WORD_W omega word out MSB first on mosi and
// captures the slave's MISO word in the same frame. All pins are registered.
module spi_omega_master
  import spi_omega_master_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int SCK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic              CLK67MHZ,
  input  logic              resetPort,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  input  logic              misoPort,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rx_data,
  output logic              sckPort,
  output logic              mosiPort,
  output logic              sselPort
);

  localparam int BIT_W = $clog2(WORD_W) + 1;
  localparam int PH_W  = $clog2(max4(SCK_DIV, CS_SETUP, CS_HOLD, CS_IDLE)) + 1;

  spi_state_t        r_state;
  logic [WORD_W-1:0] r_tx_shift;
  logic [WORD_W-1:0] r_rx_shift;
  logic [WORD_W-1:0] r_rx_data;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_sck;
  logic              r_mosi;
  logic              r_ssel;
  logic              r_busy;
  logic              r_done;

  logic              w_tc;
  logic              w_load;
  logic [PH_W-1:0]   w_load_val;
  logic              w_last;

  assign w_last = (r_bit_cnt == BIT_W'(WORD_W - 1));

  // Each timed state loads its own length minus one on entry.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        w_load     = start;
        w_load_val = PH_W'(CS_SETUP - 1);
      end
      ST_SETUP, ST_LOW: begin
        w_load     = w_tc;
        w_load_val = PH_W'(SCK_DIV - 1);
      end
      ST_HIGH: begin
        w_load     = w_tc;
        w_load_val = w_last ? PH_W'(CS_HOLD - 1) : PH_W'(SCK_DIV - 1);
      end
      ST_HOLD: begin
        w_load     = w_tc;
        w_load_val = PH_W'(CS_IDLE - 1);
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  spi_phase_timer #(
    .W (PH_W)
  ) u_timer (
    .i_clk  (CLK67MHZ),
    .i_rst  (resetPort),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_tc   (w_tc)
  );

  always_ff @(posedge CLK67MHZ or posedge resetPort) begin
    if (resetPort) begin
      r_state    <= ST_IDLE;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_sck      <= SCK_IDLE;
      r_mosi     <= 1'b0;
      r_ssel     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ssel <= 1'b1;
          r_sck  <= SCK_IDLE;
          r_mosi <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_tx_shift <= data_in;
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b1;
            r_ssel     <= 1'b0;
            r_mosi     <= data_in[WORD_W-1];
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tc) r_state <= ST_LOW;
        end
        ST_LOW: begin
          // MISO is sampled on the same edge that raises sck.
          if (w_tc) begin
            r_sck      <= ~SCK_IDLE;
            r_rx_shift <= {r_rx_shift[WORD_W-2:0], misoPort};
            r_state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tc) begin
            r_sck     <= SCK_IDLE;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last) begin
              r_mosi  <= 1'b0;
              r_state <= ST_HOLD;
            end else begin
              r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
              r_mosi     <= r_tx_shift[WORD_W-2];
              r_state    <= ST_LOW;
            end
          end
        end
        ST_HOLD: begin
          if (w_tc) begin
            r_ssel  <= 1'b1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          // rx_data only ever updates here, as a whole word.
          if (w_tc) begin
            r_rx_data <= r_rx_shift;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_data  = r_rx_data;
  assign sckPort  = r_sck;
  assign mosiPort = r_mosi;
  assign sselPort = r_ssel;

endmodule
